// File: rtl/eth_dma_rx_mq.sv
// Multi-queue receive DMA: steers each non-stallable MAC frame into a fixed-size slot
// of a per-queue buffer ring, posts completions, and counts dropped/discarded frames.
module eth_dma_rx_mq #(
    parameter int unsigned DW       = 32,
    parameter int unsigned NQ       = 4,
    parameter int unsigned NSLOT    = 8,
    parameter int unsigned MAXW     = 384,
    parameter int unsigned QSEL_LSB = 0
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          in_valid,
    input  logic [DW-1:0]                                 in_data,
    input  logic                                          in_sof,
    input  logic                                          in_eof,
    input  logic                                          in_err,
    output logic                                          mem_we,
    output logic [$clog2(NQ)+$clog2(NSLOT)+$clog2(MAXW)-1:0] mem_addr,
    output logic [DW-1:0]                                 mem_wdata,
    output logic                                          cmpl_valid,
    output logic [$clog2(NQ)-1:0]                         cmpl_queue,
    output logic [$clog2(NSLOT)-1:0]                      cmpl_slot,
    output logic [$clog2(MAXW+1)-1:0]                     cmpl_len,
    input  logic                                          rel_valid,
    input  logic [$clog2(NQ)-1:0]                         rel_queue,
    output logic [NQ-1:0]                                 q_full,
    output logic [15:0]                                   drop_cnt,
    output logic [15:0]                                   err_cnt,
    output logic                                          rel_err
);
    localparam int unsigned QW = $clog2(NQ);
    localparam int unsigned SW = $clog2(NSLOT);
    localparam int unsigned OW = $clog2(MAXW);
    localparam int unsigned LW = $clog2(MAXW + 1);
    localparam int unsigned CW = SW + 1;
    localparam int unsigned AW = QW + SW + OW;

    typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

    state_t          state, state_n;
    logic [QW-1:0]   cur_q, cur_q_n;
    logic [SW-1:0]   cur_slot, cur_slot_n;
    logic [LW-1:0]   len, len_n;
    logic [SW-1:0]   wr_ptr   [NQ];
    logic [SW-1:0]   wr_ptr_n [NQ];
    logic [CW-1:0]   count    [NQ];
    logic [CW-1:0]   count_n  [NQ];

    logic [QW-1:0]   sel_q_c;
    logic            rel_ok_c;
    logic            sel_full_c;
    logic            wr_c;
    logic [AW-1:0]   waddr_c;
    logic            commit_c;
    logic [1:0]      err_inc_c;
    logic            drop_inc_c;
    logic [16:0]     err_sum_c;
    logic [16:0]     drop_sum_c;

    // Frame steering, word placement and commit/discard decisions for this cycle
    always_comb begin
        state_n    = state;
        cur_q_n    = cur_q;
        cur_slot_n = cur_slot;
        len_n      = len;
        wr_c       = 1'b0;
        waddr_c    = '0;
        commit_c   = 1'b0;
        err_inc_c  = 2'd0;
        drop_inc_c = 1'b0;
        sel_q_c    = in_data[QSEL_LSB +: QW];
        rel_ok_c   = rel_valid && (count[rel_queue] != CW'(0));
        // A same-cycle release frees a slot before the full check
        sel_full_c = (count[sel_q_c] == CW'(NSLOT)) && !(rel_ok_c && (rel_queue == sel_q_c));

        if (in_valid) begin
            if (in_sof) begin
                if (state == RECV) begin
                    err_inc_c = 2'd1;
                end
                if (sel_full_c) begin
                    drop_inc_c = 1'b1;
                    state_n    = in_eof ? IDLE : DROP;
                end else begin
                    cur_q_n    = sel_q_c;
                    cur_slot_n = wr_ptr[sel_q_c];
                    len_n      = LW'(1);
                    wr_c       = 1'b1;
                    waddr_c    = {sel_q_c, wr_ptr[sel_q_c], OW'(0)};
                    if (in_eof) begin
                        state_n = IDLE;
                        if (in_err) begin
                            err_inc_c = err_inc_c + 2'd1;
                        end else begin
                            commit_c = 1'b1;
                        end
                    end else begin
                        state_n = RECV;
                    end
                end
            end else if (state == RECV) begin
                if (len == LW'(MAXW)) begin
                    err_inc_c = 2'd1;
                    state_n   = in_eof ? IDLE : DROP;
                end else begin
                    wr_c    = 1'b1;
                    waddr_c = {cur_q, cur_slot, len[OW-1:0]};
                    len_n   = len + LW'(1);
                    if (in_eof) begin
                        state_n = IDLE;
                        if (in_err) begin
                            err_inc_c = 2'd1;
                        end else begin
                            commit_c = 1'b1;
                        end
                    end
                end
            end else if ((state == DROP) && in_eof) begin
                state_n = IDLE;
            end
        end

        for (int i = 0; i < NQ; i++) begin
            count_n[i]  = count[i];
            wr_ptr_n[i] = wr_ptr[i];
            if (commit_c && (cur_q_n == QW'(i))) begin
                wr_ptr_n[i] = wr_ptr[i] + SW'(1);
                if (!(rel_ok_c && (rel_queue == QW'(i)))) begin
                    count_n[i] = count[i] + CW'(1);
                end
            end else if (rel_ok_c && (rel_queue == QW'(i))) begin
                count_n[i] = count[i] - CW'(1);
            end
        end

        err_sum_c  = {1'b0, err_cnt} + 17'(err_inc_c);
        drop_sum_c = {1'b0, drop_cnt} + 17'(drop_inc_c);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cur_q      <= '0;
            cur_slot   <= '0;
            len        <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cmpl_valid <= 1'b0;
            cmpl_queue <= '0;
            cmpl_slot  <= '0;
            cmpl_len   <= '0;
            q_full     <= '0;
            drop_cnt   <= '0;
            err_cnt    <= '0;
            rel_err    <= 1'b0;
            for (int i = 0; i < NQ; i++) begin
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            state      <= state_n;
            cur_q      <= cur_q_n;
            cur_slot   <= cur_slot_n;
            len        <= len_n;
            mem_we     <= wr_c;
            mem_addr   <= waddr_c;
            if (wr_c) begin
                mem_wdata <= in_data;
            end
            cmpl_valid <= commit_c;
            if (commit_c) begin
                cmpl_queue <= cur_q_n;
                cmpl_slot  <= cur_slot_n;
                cmpl_len   <= len_n;
            end
            for (int i = 0; i < NQ; i++) begin
                wr_ptr[i] <= wr_ptr_n[i];
                count[i]  <= count_n[i];
                q_full[i] <= (count_n[i] == CW'(NSLOT));
            end
            drop_cnt <= drop_sum_c[16] ? 16'hFFFF : drop_sum_c[15:0];
            err_cnt  <= err_sum_c[16] ? 16'hFFFF : err_sum_c[15:0];
            if (rel_valid && (count[rel_queue] == CW'(0))) begin
                rel_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_eth_dma_rx_mq.sv
// Directed bench for eth_dma_rx_mq: steering, ring wrap, full drop, overflow, error,
// mid-frame abort, same-cycle release, empty release and mid-frame reset.
module tb_eth_dma_rx_mq;
    localparam int unsigned DW = 32;
    localparam int unsigned NQ = 4;
    localparam int unsigned AW = 14;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, in_sof, in_eof, in_err;
    logic [DW-1:0] in_data;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          cmpl_valid;
    logic [1:0]    cmpl_queue;
    logic [2:0]    cmpl_slot;
    logic [8:0]    cmpl_len;
    logic          rel_valid;
    logic [1:0]    rel_queue;
    logic [NQ-1:0] q_full;
    logic [15:0]   drop_cnt, err_cnt;
    logic          rel_err;

    always #5 clk = ~clk;

    eth_dma_rx_mq dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_sof(in_sof), .in_eof(in_eof), .in_err(in_err), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cmpl_valid(cmpl_valid),
        .cmpl_queue(cmpl_queue), .cmpl_slot(cmpl_slot), .cmpl_len(cmpl_len),
        .rel_valid(rel_valid), .rel_queue(rel_queue), .q_full(q_full),
        .drop_cnt(drop_cnt), .err_cnt(err_cnt), .rel_err(rel_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Output monitor sampled on the falling edge
    int            n_we    = 0;
    int            n_cmpl  = 0;
    int            n_off0  = 0;
    logic [AW-1:0] last_addr  = '0;
    logic [DW-1:0] last_wdata = '0;
    logic [1:0]    c_q    = '0;
    logic [2:0]    c_slot = '0;
    logic [8:0]    c_len  = '0;

    always @(negedge clk) begin
        if (mem_we) begin
            n_we++;
            last_addr  = mem_addr;
            last_wdata = mem_wdata;
            if (mem_addr[8:0] == 9'd0) n_off0++;
        end
        if (cmpl_valid) begin
            n_cmpl++;
            c_q    = cmpl_queue;
            c_slot = cmpl_slot;
            c_len  = cmpl_len;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [31:0] addr(input int q, input int s, input int o);
        return 32'({2'(q), 3'(s), 9'(o)});
    endfunction

    function automatic logic [31:0] word(input int q, input int i);
        return 32'hA500_0000 | (32'(i) << 8) | 32'(q);
    endfunction

    task automatic drive(input logic v, input logic [31:0] d, input logic s, input logic e,
                         input logic er, input logic rv, input logic [1:0] rq);
        @(posedge clk); #1;
        in_valid = v; in_data = d; in_sof = s; in_eof = e; in_err = er;
        rel_valid = rv; rel_queue = rq;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    endtask

    task automatic send_frame(input int q, input int n, input logic err, input logic eof_last);
        for (int i = 0; i < n; i++)
            drive(1'b1, word(q, i), i == 0, eof_last && (i == n - 1),
                  err && (i == n - 1), 1'b0, 2'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_sof = 1'b0; in_eof = 1'b0;
        in_err = 1'b0; rel_valid = 1'b0; rel_queue = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    int b_we, b_cm, b_off;

    initial begin
        do_reset();
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_cmpl_valid", 32'(cmpl_valid), 32'd0);
        check("rst_q_full", 32'(q_full), 32'd0);
        check("rst_counters", {drop_cnt, err_cnt}, 32'd0);
        check("rst_rel_err", 32'(rel_err), 32'd0);

        // 1: four-word frame to queue 2
        b_we = n_we; b_cm = n_cmpl; b_off = n_off0;
        send_frame(2, 4, 1'b0, 1'b1); idle(2);
        check("t1_writes", 32'(n_we - b_we), 32'd4);
        check("t1_off0", 32'(n_off0 - b_off), 32'd1);
        check("t1_last_addr", 32'(last_addr), addr(2, 0, 3));
        check("t1_last_data", last_wdata, word(2, 3));
        check("t1_cmpls", 32'(n_cmpl - b_cm), 32'd1);
        check("t1_cmpl", {23'd0, c_q, c_slot, c_len}, {23'd0, 2'd2, 3'd0, 9'd4});

        // 2: fill queue 1, drop the ninth, release one and wrap
        for (int f = 0; f < 8; f++) begin
            send_frame(1, 2, 1'b0, 1'b1); idle(2);
            check("t2_slot", 32'(c_slot), 32'(f));
        end
        check("t2_full", 32'(q_full), 32'b0010);
        b_we = n_we; b_cm = n_cmpl;
        send_frame(1, 2, 1'b0, 1'b1); idle(2);
        check("t2_drop_writes", 32'(n_we - b_we), 32'd0);
        check("t2_drop_cmpls", 32'(n_cmpl - b_cm), 32'd0);
        check("t2_drop_cnt", 32'(drop_cnt), 32'd1);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1); idle(2);
        check("t2_rel_full", 32'(q_full), 32'd0);
        b_cm = n_cmpl;
        send_frame(1, 2, 1'b0, 1'b1); idle(2);
        check("t2_wrap_cmpls", 32'(n_cmpl - b_cm), 32'd1);
        check("t2_wrap", {23'd0, c_q, c_slot, c_len}, {23'd0, 2'd1, 3'd0, 9'd2});
        check("t2_refull", 32'(q_full), 32'b0010);

        // 3: oversize frame then a normal one
        do_reset();
        b_we = n_we; b_cm = n_cmpl;
        send_frame(3, 385, 1'b0, 1'b1); idle(2);
        check("t3_writes", 32'(n_we - b_we), 32'd384);
        check("t3_last_addr", 32'(last_addr), addr(3, 0, 383));
        check("t3_cmpls", 32'(n_cmpl - b_cm), 32'd0);
        check("t3_err_cnt", 32'(err_cnt), 32'd1);
        send_frame(3, 2, 1'b0, 1'b1); idle(2);
        check("t3_next", {23'd0, c_q, c_slot, c_len}, {23'd0, 2'd3, 3'd0, 9'd2});

        // 4: error on eof then slot reuse
        do_reset();
        b_cm = n_cmpl;
        send_frame(0, 3, 1'b1, 1'b1); idle(2);
        check("t4_cmpls", 32'(n_cmpl - b_cm), 32'd0);
        check("t4_err_cnt", 32'(err_cnt), 32'd1);
        send_frame(0, 2, 1'b0, 1'b1); idle(2);
        check("t4_reuse", {23'd0, c_q, c_slot, c_len}, {23'd0, 2'd0, 3'd0, 9'd2});

        // 5: sof arriving as word 3 aborts and restarts in the same slot
        do_reset();
        b_we = n_we; b_cm = n_cmpl; b_off = n_off0;
        send_frame(2, 3, 1'b0, 1'b0);
        send_frame(2, 2, 1'b0, 1'b1); idle(2);
        check("t5_err_cnt", 32'(err_cnt), 32'd1);
        check("t5_writes", 32'(n_we - b_we), 32'd5);
        check("t5_off0", 32'(n_off0 - b_off), 32'd2);
        check("t5_cmpls", 32'(n_cmpl - b_cm), 32'd1);
        check("t5_cmpl", {23'd0, c_q, c_slot, c_len}, {23'd0, 2'd2, 3'd0, 9'd2});

        // 6: same-cycle release on a full queue, empty release, mid-frame reset
        do_reset();
        for (int f = 0; f < 8; f++) send_frame(0, 1, 1'b0, 1'b1);
        idle(2);
        check("t6_full", 32'(q_full), 32'b0001);
        b_cm = n_cmpl;
        drive(1'b1, word(0, 0), 1'b1, 1'b1, 1'b0, 1'b1, 2'd0); idle(2);
        check("t6_rel_cmpls", 32'(n_cmpl - b_cm), 32'd1);
        check("t6_rel_cmpl", {23'd0, c_q, c_slot, c_len}, {23'd0, 2'd0, 3'd0, 9'd1});
        check("t6_still_full", 32'(q_full), 32'b0001);
        check("t6_no_drop", 32'(drop_cnt), 32'd0);
        check("t6_rel_err_pre", 32'(rel_err), 32'd0);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3); idle(2);
        check("t6_rel_err", 32'(rel_err), 32'd1);
        b_cm = n_cmpl;
        send_frame(0, 2, 1'b0, 1'b0);
        do_reset();
        idle(2);
        check("t6_rst_cmpls", 32'(n_cmpl - b_cm), 32'd0);
        check("t6_rst_state", {27'd0, mem_we, q_full}, 32'd0);
        check("t6_rst_rel_err", 32'(rel_err), 32'd0);
        send_frame(0, 1, 1'b0, 1'b1); idle(2);
        check("t6_after_rst", {23'd0, c_q, c_slot, c_len}, {23'd0, 2'd0, 3'd0, 9'd1});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
